// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the eight-way round-robin decode arbiter.
package rr_arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_3to8.sv
// Purely combinational 3-to-8 one-hot decoder.
module decoder_3to8
    import rr_arb_pkg::*;
(
    input  idx_t            idx_i,
    output logic [NREQ-1:0] onehot_o
);

    // Exactly one output bit set, selected by idx_i.
    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with registered winner index, hold-time
// preemption and a guaranteed idle cycle between consecutive grants.
//
//   state | meaning
//   IDLE  | no grant active; picks a winner when arb_en=1 and req!=0
//   GRANT | grant to gnt_idx held until release or hold limit reached
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arb_en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDX_W-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            preempt
);

    // With HOLD_MAX = 0 the compare value is irrelevant; PREEMPT_EN masks it.
    localparam bit               PREEMPT_EN = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    idx_t             ptr_q;
    idx_t             gnt_idx_q;
    logic             gnt_valid_q;
    logic             preempt_q;
    logic [CNT_W-1:0] hold_cnt_q;
    idx_t             win_idx_d;
    logic [NREQ-1:0]  dec_onehot;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic idx_t rr_pick(input logic [NREQ-1:0] r, input idx_t p);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        idx_t              off;
        dbl = {r, r} >> p;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = idx_t'(i);
        end
        return idx_t'(p + off);
    endfunction

    // Candidate winner from the current pointer; only used in IDLE.
    always_comb begin
        win_idx_d = rr_pick(req, ptr_q);
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_en && (|req)) begin
                        gnt_idx_q   <= win_idx_d;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    // Release wins over preemption when both hit on the same edge.
                    if (!req[gnt_idx_q]) begin
                        state_q     <= IDLE;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= idx_t'(gnt_idx_q + idx_t'(1));
                    end else if (PREEMPT_EN && (hold_cnt_q == HOLD_LAST)) begin
                        state_q     <= IDLE;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= idx_t'(gnt_idx_q + idx_t'(1));
                        preempt_q   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    decoder_3to8 u_dec (
        .idx_i    (gnt_idx_q),
        .onehot_o (dec_onehot)
    );

    assign grant     = dec_onehot & {NREQ{gnt_valid_q}};
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule
